class_mem_read_sequencer: RTL and testbench

// Sequences read-out of the 16-bank class hypervector memory after loading completes.
// On start, walks every row of every class in order: class 0 chunk 0 .. class C-1 chunk R-1.

---
 rtl/class_mem_read_sequencer_if.sv | 34 +++
 rtl/class_mem_read_sequencer.sv | 162 ++++++++++++++++
 tb/tb_class_mem_read_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/class_mem_read_sequencer_if.sv
// Memory read port and row stream between the class-memory read sequencer and its neighbours.
interface class_mem_read_sequencer_if #(
  parameter int unsigned N_SIZE     = 16,
  parameter int unsigned FTWIDTH    = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned CW         = 5
);
  logic                        mem_re;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [N_SIZE*FTWIDTH-1:0]   mem_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_SIZE*FTWIDTH-1:0]   out_data;
  logic [4:0]                  out_class;
  logic [CW-1:0]               out_chunk;
  logic                        out_last_chunk;
  logic                        out_last_class;

  modport master (
    output mem_re, mem_addr,
    input  mem_data,
    output out_valid,
    input  out_ready,
    output out_data, out_class, out_chunk, out_last_chunk, out_last_class
  );

  modport slave (
    input  mem_re, mem_addr,
    output mem_data,
    input  out_valid,
    output out_ready,
    input  out_data, out_class, out_chunk, out_last_chunk, out_last_class
  );
endinterface

// File: rtl/class_mem_read_sequencer.sv
// Walks every row of every class in the class memory and streams the rows out.
// Optional stall counter output enabled by defining CLASS_SEQ_STALL_CNT_EN.
module class_mem_read_sequencer #(
  parameter int unsigned DIV_SIZE   = 512,
  parameter int unsigned N_SIZE     = 16,
  parameter int unsigned FTWIDTH    = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MAX_CLASS  = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  class_num,
  input  logic        write_done,
  output logic        busy,
  output logic        done,
  output logic        error,
`ifdef CLASS_SEQ_STALL_CNT_EN
  output logic [15:0] stall_cycles,
`endif
  class_mem_read_sequencer_if.master bus
);

  localparam int unsigned ROWS = DIV_SIZE / N_SIZE;
  localparam int unsigned CW   = $clog2(ROWS);
  localparam int unsigned DW   = N_SIZE * FTWIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnum_q;
  logic [4:0]            cls_q, cls_d;
  logic [CW-1:0]         chunk_q, chunk_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;
  logic [4:0]            tag_cls_q;
  logic [CW-1:0]         tag_chunk_q;
  logic [DW-1:0]         fifo_data_q  [2];
  logic [4:0]            fifo_cls_q   [2];
  logic [CW-1:0]         fifo_chunk_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;
  logic                  error_q;

  logic                  req_ok, accept, issue, push, pop, last_row;
  logic [2:0]            pending;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign req_ok   = write_done && (class_num != 5'd0) && ({27'd0, class_num} <= MAX_CLASS);
  assign accept   = (state_q == StIdle) && start && req_ok;
  assign pop      = bus.out_valid && bus.out_ready;
  assign push     = inflight_q;
  // Entries the FIFO will hold after this edge, counting the read still in the memory.
  assign pending  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign cur_addr = ADDR_WIDTH'(cls_q) * ADDR_WIDTH'(ROWS) + ADDR_WIDTH'(chunk_q);
  assign last_row = (chunk_q == CW'(ROWS - 1)) && (cls_q == cnum_q - 5'd1);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    chunk_d = chunk_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          cls_d   = 5'd0;
          chunk_d = '0;
        end
      end
      StRun: begin
        if (pending < 3'd2) begin
          issue = 1'b1;
          if (chunk_q == CW'(ROWS - 1)) begin
            chunk_d = '0;
            cls_d   = cls_q + 5'd1;
          end else begin
            chunk_d = chunk_q + CW'(1);
          end
          if (last_row) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pending == 3'd0) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnum_q      <= 5'd0;
      cls_q       <= 5'd0;
      chunk_q     <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      tag_cls_q   <= 5'd0;
      tag_chunk_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      error_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_cls_q[i]   <= 5'd0;
        fifo_chunk_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      chunk_q    <= chunk_d;
      error_q    <= (state_q == StIdle) && start && !req_ok;
      inflight_q <= issue;
      if (accept) cnum_q <= class_num;
      if (issue) begin
        addr_q      <= cur_addr;
        tag_cls_q   <= cls_q;
        tag_chunk_q <= chunk_q;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q]  <= bus.mem_data;
        fifo_cls_q[wr_ptr_q]   <= tag_cls_q;
        fifo_chunk_q[wr_ptr_q] <= tag_chunk_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

  assign busy  = (state_q == StRun) || (state_q == StDrain);
  assign done  = (state_q == StDone);
  assign error = error_q;

  assign bus.mem_re         = issue;
  assign bus.mem_addr       = issue ? cur_addr : addr_q;
  assign bus.out_valid      = (occ_q != 2'd0);
  assign bus.out_data       = fifo_data_q[rd_ptr_q];
  assign bus.out_class      = fifo_cls_q[rd_ptr_q];
  assign bus.out_chunk      = fifo_chunk_q[rd_ptr_q];
  assign bus.out_last_chunk = (fifo_chunk_q[rd_ptr_q] == CW'(ROWS - 1));
  assign bus.out_last_class = (fifo_cls_q[rd_ptr_q] == cnum_q - 5'd1);

`ifdef CLASS_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'd0;
    end else if (accept) begin
      stall_q <= 16'd0;
    end else if (busy && bus.out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_class_mem_read_sequencer.sv
// Directed bench for class_mem_read_sequencer with a 1-cycle-latency memory model.
module tb_class_mem_read_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] class_num;
  logic       write_done;
  logic       busy;
  logic       done;
  logic       error;
`ifdef CLASS_SEQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  class_mem_read_sequencer_if bus_if ();

  class_mem_read_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .class_num    (class_num),
    .write_done   (write_done),
    .busy         (busy),
    .done         (done),
    .error        (error),
`ifdef CLASS_SEQ_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] row(input int a);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(a * 8 + i) ^ 16'h5A00;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus_if.mem_re) bus_if.mem_data <= row(int'(bus_if.mem_addr));
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One pass; optional out_ready stall window, mid-pass start pulse, or early return.
  task automatic run_pass(input logic [4:0] cnum, input int stall_at, input int stall_len,
                          input int restart_at, input int abort_after);
    int k, issued, first_v, last_hs, done_cyc, dones, errs, max_out, re_in_stall, budget;
    logic stall;
    logic [139:0] exp_b, obs_b;
    k = 0; issued = 0; first_v = -1; last_hs = -1; done_cyc = -1;
    dones = 0; errs = 0; max_out = 0; re_in_stall = 0;
    budget = int'(cnum) * 32 + stall_len + 20;
    write_done = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start            = (cyc == 0) || (cyc == restart_at);
      class_num        = (cyc == restart_at) ? 5'd5 : cnum;
      stall            = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      bus_if.out_ready = !stall;
      #1;
      if (cyc == 1) chk("busy_in_run", 160'(busy), 160'(1));
      if (bus_if.mem_re) begin
        chk("mem_addr_issue", 160'(bus_if.mem_addr), 160'(issued));
        issued++;
        if (stall) re_in_stall++;
      end
      if (bus_if.out_valid && first_v < 0) first_v = cyc;
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk("busy_at_done", 160'(busy), 160'(0));
      end
      if (error) errs++;
      if (bus_if.out_valid && bus_if.out_ready) begin
        exp_b = {row(k), 5'(k / 32), 5'(k % 32), (k % 32) == 31, (k / 32) == (int'(cnum) - 1)};
        obs_b = {bus_if.out_data, bus_if.out_class, bus_if.out_chunk,
                 bus_if.out_last_chunk, bus_if.out_last_class};
        chk("beat", 160'(obs_b), 160'(exp_b));
        k++;
        last_hs = cyc;
      end
      if (issued - k > max_out) max_out = issued - k;
      if (abort_after > 0 && k == abort_after) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    bus_if.out_ready = 1'b1;
    if (abort_after == 0) begin
      chk("beat_count", 160'(k), 160'(int'(cnum) * 32));
      chk("done_pulses", 160'(dones), 160'(1));
      chk("done_after_last_hs", 160'(done_cyc), 160'(last_hs + 1));
      chk("first_valid_latency", 160'(first_v), 160'(3));
      chk("no_error_in_pass", 160'(errs), 160'(0));
      chk("mem_addr_hold", 160'(bus_if.mem_addr), 160'(int'(cnum) * 32 - 1));
      chk("max_outstanding", 160'(max_out), 160'(2));
      chk("mem_re_during_stall", 160'(re_in_stall), 160'(0));
      chk("busy_after_pass", 160'(busy), 160'(0));
`ifdef CLASS_SEQ_STALL_CNT_EN
      chk("stall_cycles", 160'(stall_cycles), 160'(stall_len));
`endif
    end
  endtask

  task automatic bad_start(input logic [4:0] cnum, input logic wd, input string tag);
    @(negedge clk);
    start = 1'b1; class_num = cnum; write_done = wd;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_error"}, 160'(error), 160'(1));
    chk({tag, "_busy"}, 160'(busy), 160'(0));
    chk({tag, "_mem_re"}, 160'(bus_if.mem_re), 160'(0));
    chk({tag, "_valid"}, 160'(bus_if.out_valid), 160'(0));
    @(negedge clk);
    #1;
    chk({tag, "_error_pulse_end"}, 160'(error), 160'(0));
    chk({tag, "_valid_after"}, 160'(bus_if.out_valid), 160'(0));
    write_done = 1'b1;
  endtask

  initial begin
    int d;
    reset = 1'b1; start = 1'b0; class_num = 5'd0; write_done = 1'b1;
    bus_if.out_ready = 1'b1;
    bus_if.mem_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_done", 160'(done), 160'(0));
    chk("rst_error", 160'(error), 160'(0));
    chk("rst_mem_re", 160'(bus_if.mem_re), 160'(0));
    chk("rst_mem_addr", 160'(bus_if.mem_addr), 160'(0));
    chk("rst_valid", 160'(bus_if.out_valid), 160'(0));
    chk("rst_tags", 160'({bus_if.out_data, bus_if.out_class, bus_if.out_chunk,
                          bus_if.out_last_chunk, bus_if.out_last_class}), 160'(0));
    @(negedge clk);
    reset = 1'b0;

    // Two classes, free-flowing output.
    run_pass(5'd2, 1000000, 0, 1000000, 0);
    // Largest legal class count.
    run_pass(5'd26, 1000000, 0, 1000000, 0);
    // Ten-cycle backpressure mid-pass.
    run_pass(5'd3, 40, 10, 1000000, 0);

    bad_start(5'd0, 1'b1, "cnum0");
    bad_start(5'd27, 1'b1, "cnum27");
    bad_start(5'd4, 1'b0, "not_loaded");

    // Abort a pass with reset after 20 beats.
    run_pass(5'd4, 1000000, 0, 1000000, 20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 160'(busy), 160'(0));
    chk("abort_valid", 160'(bus_if.out_valid), 160'(0));
    chk("abort_mem_re", 160'(bus_if.mem_re), 160'(0));
    chk("abort_data", 160'(bus_if.out_data), 160'(0));
    d = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (done || bus_if.out_valid || bus_if.mem_re) d++;
    end
    chk("abort_quiet", 160'(d), 160'(0));
    run_pass(5'd1, 1000000, 0, 1000000, 0);

    // Start pulse with a different class_num mid-run is ignored.
    run_pass(5'd2, 1000000, 0, 10, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
